// File: rtl/seq_mul_if.sv
// seq_mul_if: request/response bundle for the sequential multiplier.
//   start, is_signed, multiplicand, multiplier : requester -> multiplier
//   ready, done, product                       : multiplier -> requester
// The master modport is the requester side. The slave modport is the multiplier.
interface seq_mul_if #(
    parameter int WIDTH = 32
);
    logic                 start;
    logic                 is_signed;
    logic [WIDTH-1:0]     multiplicand;
    logic [WIDTH-1:0]     multiplier;
    logic                 ready;
    logic                 done;
    logic [2*WIDTH-1:0]   product;

    modport master (
        output start, is_signed, multiplicand, multiplier,
        input  ready, done, product
    );

    modport slave (
        input  start, is_signed, multiplicand, multiplier,
        output ready, done, product
    );
endinterface

// File: rtl/seq_mul.sv
// seq_mul: radix-2 shift-and-add multiplier that consumes one multiplier bit per clock.
// Ports:
//   clk    - system clock; all state changes on the rising edge
//   rst_n  - asynchronous active-low reset
//   bus    - seq_mul_if.slave:
//              start/is_signed/multiplicand/multiplier are sampled when ready=1,
//              ready is high in IDLE,
//              done is a one-cycle pulse when product updates,
//              product holds the last completed 2*WIDTH result.
// Timing: if start is accepted at edge T, the product and done appear after edge T+WIDTH+1.
// Signed operands are multiplied as magnitudes. The sign is applied in a single FIX cycle.
module seq_mul #(
    parameter int WIDTH = 32
) (
    input  logic      clk,
    input  logic      rst_n,
    seq_mul_if.slave  bus
);
    localparam int            CW       = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [2*WIDTH-1:0]   product_q, product_d;
    logic [WIDTH-1:0]     a_q, a_d;
    logic [WIDTH-1:0]     b_q, b_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 neg_q, neg_d;
    logic                 done_q, done_d;
    logic                 ready;

    logic [WIDTH-1:0]     a_mag, b_mag;
    logic [CW-1:0]        shamt;
    logic [2*WIDTH-1:0]   a_shift;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = RUN;
            // cnt_q==1 means this edge handles the last bit.
            RUN:     if (cnt_q == CW'(1)) state_d = FIX;
            FIX:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        ready = (state_q == IDLE);
    end

    assign bus.ready   = ready;
    assign bus.done    = done_q;
    assign bus.product = product_q;

    // Datapath
    always_comb begin
        // Negating -2^(WIDTH-1) returns the same bit pattern.
        // Read as an unsigned value, that pattern is exactly the magnitude 2^(WIDTH-1).
        a_mag = (bus.is_signed && bus.multiplicand[WIDTH-1]) ? -bus.multiplicand : bus.multiplicand;
        b_mag = (bus.is_signed && bus.multiplier[WIDTH-1])   ? -bus.multiplier   : bus.multiplier;

        // The bit handled this cycle has weight 2^(WIDTH-cnt).
        shamt   = CNT_INIT - cnt_q;
        a_shift = {{WIDTH{1'b0}}, a_q} << shamt;

        acc_d     = acc_q;
        a_d       = a_q;
        b_d       = b_q;
        cnt_d     = cnt_q;
        neg_d     = neg_q;
        product_d = product_q;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_d   = a_mag;
                    b_d   = b_mag;
                    neg_d = bus.is_signed & (bus.multiplicand[WIDTH-1] ^ bus.multiplier[WIDTH-1]);
                    acc_d = '0;
                    cnt_d = CNT_INIT;
                end
            end
            RUN: begin
                if (b_q[0]) acc_d = acc_q + a_shift;
                b_d   = b_q >> 1;
                cnt_d = cnt_q - CW'(1);
            end
            FIX: begin
                // Negating a zero accumulator gives zero, so a zero result is never reported as -0.
                product_d = neg_q ? -acc_q : acc_q;
                done_d    = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            cnt_q     <= '0;
            neg_q     <= 1'b0;
            product_q <= '0;
            done_q    <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            a_q       <= a_d;
            b_q       <= b_d;
            cnt_q     <= cnt_d;
            neg_q     <= neg_d;
            product_q <= product_d;
            done_q    <= done_d;
        end
    end
endmodule

// File: tb/tb_seq_mul.sv
// tb_seq_mul: directed tests for seq_mul.
// A transaction-level model runs alongside the DUT. It records accepted operations,
// computes the product arithmetically, and schedules done WIDTH+1 edges after acceptance.
// A negedge process compares ready, done and product against this model on every cycle.
// Each directed test also compares its result against a literal value worked out by hand.
module tb_seq_mul;
    localparam int W = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    seq_mul_if #(.WIDTH(W)) bus();

    seq_mul #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_pass = 0;
    int n_tot  = 0;
    int cyc    = 0;
    logic chk_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%h expected 0x%h (cycle %0d)", nm, act, exp, cyc);
    endtask

    function automatic logic [63:0] ref_mul(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
        logic signed [63:0] sa, sb;
        if (s) begin
            sa = {{W{a[W-1]}}, a};
            sb = {{W{b[W-1]}}, b};
            return sa * sb;
        end
        return {{W{1'b0}}, a} * {{W{1'b0}}, b};
    endfunction

    // Transaction-level model: one operation in flight, result due W+1 edges after accept.
    logic        m_busy;
    int          m_rem;
    logic [63:0] m_pend, m_prod;
    logic        m_done;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0;
            m_rem  <= 0;
            m_pend <= '0;
            m_prod <= '0;
            m_done <= 1'b0;
        end else begin
            m_done <= 1'b0;
            if (!m_busy) begin
                if (bus.start) begin
                    m_busy <= 1'b1;
                    m_rem  <= W + 1;
                    m_pend <= ref_mul(bus.is_signed, bus.multiplicand, bus.multiplier);
                end
            end else if (m_rem == 1) begin
                m_busy <= 1'b0;
                m_done <= 1'b1;
                m_prod <= m_pend;
            end else begin
                m_rem <= m_rem - 1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("ready_vs_model",   64'(bus.ready),   64'(!m_busy));
            chk("done_vs_model",    64'(bus.done),    64'(m_done));
            chk("product_vs_model", bus.product,      m_prod);
        end
    end

    task automatic start_op(input logic s, input logic [W-1:0] a, input logic [W-1:0] b, output int t0);
        int i;
        for (i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.ready) break;
        end
        if (i == 100) chk("ready_timeout", 64'(0), 64'(1));
        bus.start        = 1'b1;
        bus.is_signed    = s;
        bus.multiplicand = a;
        bus.multiplier   = b;
        @(posedge clk);
        #1 t0 = cyc;
        @(negedge clk);
        // Scramble the inputs to show they no longer matter after acceptance.
        bus.start        = 1'b0;
        bus.is_signed    = ~s;
        bus.multiplicand = $urandom;
        bus.multiplier   = $urandom;
    endtask

    task automatic wait_done(output int td);
        int i;
        td = -1;
        for (i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.done) begin
                td = cyc;
                break;
            end
        end
        if (td < 0) chk("done_timeout", 64'(0), 64'(1));
    endtask

    task automatic count_done(input int n, output int c);
        c = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (bus.done) c++;
        end
    endtask

    task automatic do_op(input string nm, input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [63:0] lit);
        int t0, td;
        start_op(s, a, b, t0);
        wait_done(td);
        chk({nm, "_latency"}, 64'(td - t0), 64'(W + 1));
        chk({nm, "_product"}, bus.product, lit);
        chk({nm, "_ready"},   64'(bus.ready), 64'(1));
    endtask

    initial begin
        int t0, td1, td2, nd;
        bus.start        = 1'b0;
        bus.is_signed    = 1'b0;
        bus.multiplicand = '0;
        bus.multiplier   = '0;
        rst_n            = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_product", bus.product, 64'h0);
        chk("reset_ready",   64'(bus.ready), 64'(1));
        chk("reset_done",    64'(bus.done),  64'(0));
        rst_n  = 1'b1;
        chk_en = 1'b1;

        do_op("u7x6",   1'b0, 32'd7,        32'd6,        64'h0000_0000_0000_002A);
        do_op("umax",   1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFF_FFFE_0000_0001);
        do_op("uzero",  1'b0, 32'd0,        32'h12345678, 64'h0);
        do_op("sm3x5",  1'b1, 32'hFFFFFFFD, 32'd5,        64'hFFFF_FFFF_FFFF_FFF1);
        do_op("sminsq", 1'b1, 32'h80000000, 32'h80000000, 64'h4000_0000_0000_0000);
        do_op("smin1",  1'b1, 32'h80000000, 32'd1,        64'hFFFF_FFFF_8000_0000);

        // Busy rejection: a second start pulse at T+10 with new operands is ignored.
        start_op(1'b0, 32'd2, 32'd3, t0);
        repeat (9) @(negedge clk);
        bus.start = 1'b1; bus.multiplicand = 32'd9; bus.multiplier = 32'd9;
        @(negedge clk);
        bus.start = 1'b0;
        chk("busy_prod_held", bus.product, 64'hFFFF_FFFF_8000_0000);
        wait_done(td1);
        chk("busy_latency", 64'(td1 - t0), 64'(W + 1));
        chk("busy_product", bus.product, 64'd6);
        count_done(40, nd);
        chk("busy_single_done", 64'(nd), 64'(0));

        // Back-to-back: start held high across the done cycle.
        start_op(1'b0, 32'd4, 32'd4, t0);
        bus.start = 1'b1; bus.is_signed = 1'b0; bus.multiplicand = 32'd5; bus.multiplier = 32'd5;
        wait_done(td1);
        chk("b2b_first_latency", 64'(td1 - t0), 64'(W + 1));
        chk("b2b_first_product", bus.product, 64'd16);
        chk("b2b_first_ready",   64'(bus.ready), 64'(1));
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(td2);
        chk("b2b_spacing",        64'(td2 - td1), 64'(W + 2));
        chk("b2b_second_product", bus.product, 64'd25);
        chk("b2b_second_ready",   64'(bus.ready), 64'(1));

        // Reset mid-operation aborts with no done pulse.
        start_op(1'b0, 32'd100, 32'd100, t0);
        repeat (14) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_mid_product", bus.product, 64'h0);
        chk("rst_mid_ready",   64'(bus.ready), 64'(1));
        rst_n = 1'b1;
        count_done(40, nd);
        chk("rst_mid_no_done", 64'(nd), 64'(0));
        do_op("post_rst_3x3", 1'b0, 32'd3, 32'd3, 64'd9);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule

// File: doc/seq_mul.md
Name: seq_mul

Overview:
- Sequential radix-2 shift-and-add multiplier; the inverse-operation companion to the iterative divider in the accum_avg datapath.
- Scales averaged results back up, e.g. mean x count, gain correction.
- Processes one multiplier bit per clock, with a start/ready/done handshake.
- Supports unsigned and two's-complement signed operands via a per-operation mode bit.

Parameters:
- WIDTH, 32, operand width in bits; product is 2*WIDTH bits; legal range 4..64.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request; accepted only on an edge where ready=1
- is_signed  in  1  1 = operands are two's complement, 0 = unsigned; sampled with start
- multiplicand  in  WIDTH  operand A; sampled with start
- multiplier  in  WIDTH  operand B; sampled with start
- ready  out  1  high in IDLE; combinational from state
- done  out  1  one-cycle pulse when product updates
- product  out  2*WIDTH  last completed result; held until next completion

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values:
  - state = IDLE, ready = 1, done = 0, product = 0.
  - Internal accumulator, operand copies, bit counter and sign flag all = 0.
- States: IDLE, RUN, FIX.
- IDLE:
  - On an edge with start=1, latch operands and move to RUN.
  - If is_signed=1: store |A| and |B| as WIDTH-bit unsigned magnitudes, and set neg = A[MSB] xor B[MSB].
  - If is_signed=0: store operands as-is, neg = 0.
  - Clear the 2*WIDTH accumulator. Load bit counter = WIDTH.
  - start=0: remain in IDLE, no state change.
- RUN, each edge:
  - If B_copy[0]=1, acc = acc + (A_copy zero-extended to 2*WIDTH, shifted left by WIDTH-counter).
  - Equivalent add-then-shift-right form is acceptable if the result is bit-identical.
  - B_copy shifts right by 1; counter decrements.
  - When the counter reaches 0 after this edge's update, go to FIX.
  - Exactly WIDTH edges in RUN.
- FIX, one edge:
  - product <= neg ? (~acc + 1) : acc, all 2*WIDTH bits.
  - done <= 1; state -> IDLE.
- Latency:
  - Start accepted at edge T; done=1 and the new product are visible after edge T+WIDTH+1.
  - This is WIDTH+1 clocks after accept (33 for the default).
- done timing:
  - High for exactly one cycle; cleared on the next edge unless another FIX occurs (impossible back-to-back).
  - ready returns high in the same cycle done is high.
- Back-to-back: start held high through done is accepted on the edge ending the done cycle. Sustained throughput is one result per WIDTH+2 clocks.
- start while RUN/FIX: ignored, no queuing, no error. Operand/is_signed changes after acceptance have no effect.
- Width rules:
  - Signed magnitude of -2^(WIDTH-1) is 2^(WIDTH-1) and fits in WIDTH unsigned bits; no overflow.
  - Max signed product (-2^(WIDTH-1))^2 = 2^(2*WIDTH-2) fits in the 2*WIDTH signed range.
  - The unsigned max (2^WIDTH-1)^2 fits in 2*WIDTH bits; the accumulator never wraps.
- Zero operands: the operation still takes full latency. The result is exactly 0, with no -0 artifact: negating 0 yields 0.
- Reset mid-operation: immediate abort. All registers return to reset values and product reads 0. No done pulse is produced for the aborted operation.
- product is not combinationally tied to the accumulator; it changes only in FIX or reset.

Test Plan:
- Unsigned 7 x 6, start 1 cycle -> ready low for 33 cycles. After edge T+33: done=1 for one cycle, product=0x000000000000002A, ready=1.
- Unsigned 0xFFFFFFFF x 0xFFFFFFFF -> product=0xFFFFFFFE00000001. Also 0 x 0x12345678 -> product=0, with done at the same latency.
- Signed -3 (0xFFFFFFFD) x 5 -> 0xFFFFFFFFFFFFFFF1. Signed 0x80000000 x 0x80000000 -> 0x4000000000000000. Signed 0x80000000 x 1 -> 0xFFFFFFFF80000000.
- Busy rejection: start 2x3; pulse start with 9x9 at cycle T+10 and change operands -> single done with product=6; product unchanged before that done.
- Back-to-back: hold start high with 4x4, then 5x5 -> done pulses 34 cycles apart, products 16 then 25. ready high in each done cycle.
- Reset mid-op: start 100x100, assert rst_n=0 at T+15 for 2 cycles -> product=0, done never pulses, ready=1. A fresh 3x3 afterwards yields 9 with normal latency.
